// File: rtl/key_debounce_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Imported by the conditioner top and its bus interface users.
package key_cond_pkg;

    localparam int KEY_CNT_W = 8;

    typedef enum logic [1:0] {
        UP,
        WAIT_DOWN,
        DOWN,
        WAIT_UP
    } key_state_t;

endpackage

// File: rtl/key_debounce_conditioner_if.sv
// Bundle of the raw key input and the conditioned key outputs.
// The design side uses master, the consumer/driver side uses slave.
interface key_cond_if;

    logic                              key_raw;
    logic                              key_level;
    logic                              press_pulse;
    logic                              release_pulse;
    logic [key_cond_pkg::KEY_CNT_W-1:0] press_count;

    modport master (
        input  key_raw,
        output key_level,
        output press_pulse,
        output release_pulse,
        output press_count
    );

    modport slave (
        output key_raw,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );

endinterface

// File: rtl/key_debounce_conditioner_sync.sv
// N-stage reset-valued synchronizer for asynchronous pin inputs.
// Shared by every KEY/SW feed into the PIO block.
module key_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/key_debounce_conditioner.sv
// Debounces one KEY pin into a level, press/release strobes and a
// wrapping press counter; every output comes straight from a flop.
module key_debounce_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic      clk,
    input  logic      reset_n,
    key_cond_if.master bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic sync_s;
    logic p_s;

    key_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 rel_q, rel_d;
    logic [KEY_CNT_W-1:0] count_q, count_d;

    // Synchronizer idles at the released pin level so reset looks like "up"
    key_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.key_raw),
        .q_o     (sync_s)
    );

    assign p_s = sync_s ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UP;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        count_d = count_q;
        unique case (state_q)
            UP: begin
                if (p_s) begin
                    state_d = WAIT_DOWN;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_DOWN: begin
                if (!p_s) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + KEY_CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if (!p_s) begin
                    state_d = WAIT_UP;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_UP: begin
                if (p_s) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = UP;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.key_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.press_count   = count_q;

endmodule

// File: tb/tb_key_debounce_conditioner.sv
// Scoreboard bench: run-length reference model vs. conditioner outputs.
// Directed test-plan scenarios followed by random bouncing.
module tb_key_debounce_conditioner;

    localparam int D = 4;
    localparam int S = 2;

    logic clk;
    logic reset_n;
    key_cond_if bus ();

    key_debounce_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int pcnt = 0;
    int rcnt = 0;
    logic [10:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: p is the raw pin S edges late; the level flips once p
    // has disagreed with it for D consecutive edges.
    initial begin
        logic hist[$];
        logic praw, p, lvl, pp, rp;
        int run;
        logic [7:0] cnt;
        lvl = 1'b0; run = 0; cnt = 8'd0;
        for (int i = 0; i < S; i++) hist.push_back(1'b1);
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                hist.delete();
                for (int i = 0; i < S; i++) hist.push_back(1'b1);
                lvl = 1'b0; run = 0; cnt = 8'd0;
                exp_q.delete();
            end else begin
                praw = hist.pop_front();
                hist.push_back(bus.key_raw);
                p = ~praw;
                pp = 1'b0;
                rp = 1'b0;
                if (p != lvl) begin
                    run++;
                    if (run == D) begin
                        lvl = p;
                        run = 0;
                        if (p) begin
                            pp = 1'b1;
                            cnt = cnt + 8'd1;
                        end else begin
                            rp = 1'b1;
                        end
                    end
                end else begin
                    run = 0;
                end
                exp_q.push_back({lvl, pp, rp, cnt});
            end
        end
    end

    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (bus.press_pulse) pcnt++;
            if (bus.release_pulse) rcnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_level", int'(bus.key_level), int'(e[10]));
                chk("sb_press", int'(bus.press_pulse), int'(e[9]));
                chk("sb_release", int'(bus.release_pulse), int'(e[8]));
                chk("sb_count", int'(bus.press_count), int'(e[7:0]));
            end
        end
    end

    task automatic set_key(input logic v);
        bus.key_raw = v;
    endtask

    task automatic drive(input logic v, input int n);
        bus.key_raw = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edge index (0 = first edge after call) at which key_level hits target
    task automatic measure(input logic target, output int edge_n);
        edge_n = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.key_level == target) begin
                edge_n = i;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int p0;
        int r0;
        bus.key_raw = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", int'(bus.key_level), 0);
        chk("rst_press", int'(bus.press_pulse), 0);
        chk("rst_release", int'(bus.release_pulse), 0);
        chk("rst_count", int'(bus.press_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 4);

        set_key(1'b0);
        measure(1'b1, e);
        chk("press_latency", e, 5);
        drive(1'b0, 14);
        chk("press_count1", int'(bus.press_count), 1);

        r0 = rcnt;
        set_key(1'b1);
        measure(1'b0, e);
        chk("release_latency", e, 5);
        drive(1'b1, 14);
        chk("release_strobes", rcnt - r0, 1);
        chk("release_count", int'(bus.press_count), 1);

        p0 = pcnt;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2);
            drive(1'b1, 2);
        end
        chk("bounce_nostrobe", pcnt - p0, 0);
        set_key(1'b0);
        measure(1'b1, e);
        chk("bounce_latency", e, 5);
        drive(1'b0, 10);
        chk("bounce_strobes", pcnt - p0, 1);
        chk("bounce_count", int'(bus.press_count), 2);
        drive(1'b1, 14);

        p0 = pcnt;
        drive(1'b0, 3);
        drive(1'b1, 15);
        chk("glitch_level", int'(bus.key_level), 0);
        chk("glitch_strobes", pcnt - p0, 0);
        chk("glitch_count", int'(bus.press_count), 2);

        p0 = pcnt;
        for (int k = 0; k < 256; k++) begin
            drive(1'b0, 8);
            drive(1'b1, 8);
        end
        chk("wrap_strobes", pcnt - p0, 256);
        chk("wrap_count", int'(bus.press_count), 2);

        for (int k = 0; k < 200; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        drive(1'b1, 20);
        if (bus.press_count == 8'd0) begin
            drive(1'b0, 10);
            drive(1'b1, 20);
        end

        set_key(1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_level", int'(bus.key_level), 0);
        chk("midrst_press", int'(bus.press_pulse), 0);
        chk("midrst_release", int'(bus.release_pulse), 0);
        chk("midrst_count", int'(bus.press_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        measure(1'b1, e);
        chk("midrst_latency", e, 5);
        drive(1'b0, 10);
        chk("midrst_count1", int'(bus.press_count), 1);
        drive(1'b1, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
